// File: rtl/flag_unit_if.sv
// Condition-flag interface: request channel, flush, commit channel and flag state.
interface flag_unit_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NFLAGS = 4
);
    localparam int unsigned FW = $clog2(NFLAGS);

    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [FW-1:0]     req_flag;
    logic [FW-1:0]     req_src_flag;
    logic [XLEN-1:0]   req_operand1;
    logic [XLEN-1:0]   req_operand2;
    logic              flush;
    logic [NFLAGS-1:0] flags;
    logic [NFLAGS-1:0] flags_pending;
    logic              write_valid;
    logic              write_ready;
    logic [FW-1:0]     write_flag;
    logic              write_value;

    // Requester / retire side
    modport master (
        output req_valid, req_op, req_flag, req_src_flag, req_operand1, req_operand2,
        output flush, write_ready,
        input  req_ready, flags, flags_pending, write_valid, write_flag, write_value
    );

    // Flag unit side
    modport slave (
        input  req_valid, req_op, req_flag, req_src_flag, req_operand1, req_operand2,
        input  flush, write_ready,
        output req_ready, flags, flags_pending, write_valid, write_flag, write_value
    );
endinterface

// File: rtl/flag_unit.sv
// Condition-flag producer: two-stage (execute, writeback) flag-write pipeline
// owning the architectural flag register, with W-to-E bypass and retire backpressure.
module flag_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NFLAGS = 4
) (
    input  logic        clk,
    input  logic        rst,
    flag_unit_if.slave  bus
);
    localparam int unsigned FW = $clog2(NFLAGS);

    localparam logic [3:0] OP_EQ     = 4'h0;
    localparam logic [3:0] OP_NE     = 4'h1;
    localparam logic [3:0] OP_UGE    = 4'h2;
    localparam logic [3:0] OP_UGT    = 4'h3;
    localparam logic [3:0] OP_SGE    = 4'h4;
    localparam logic [3:0] OP_SGT    = 4'h5;
    localparam logic [3:0] OP_SET    = 4'h6;
    localparam logic [3:0] OP_CLEAR  = 4'h7;
    localparam logic [3:0] OP_TOGGLE = 4'h8;
    localparam logic [3:0] OP_COPY   = 4'h9;

    // E stage registers
    logic              e_valid;
    logic [3:0]        e_op;
    logic [FW-1:0]     e_flag;
    logic [FW-1:0]     e_src;
    logic [XLEN-1:0]   e_a;
    logic [XLEN-1:0]   e_b;
    // W stage registers
    logic              w_valid;
    logic [FW-1:0]     w_flag;
    logic              w_value;
    // Architectural flags
    logic [NFLAGS-1:0] flags_q;

    logic              e_advance;
    logic              e_reserved;
    logic              e_fwd;
    logic              accept;
    logic              e_result;
    logic [NFLAGS-1:0] cur_vec;
    logic [NFLAGS-1:0] pending;

    assign e_advance  = !w_valid || bus.write_ready;
    assign e_reserved = (e_op > OP_COPY);
    assign e_fwd      = e_valid && !e_reserved;
    assign accept     = bus.req_valid && bus.req_ready;

    assign bus.req_ready     = !rst && !bus.flush && (!e_valid || e_advance);
    assign bus.flags         = flags_q;
    assign bus.flags_pending = pending;
    assign bus.write_valid   = w_valid;
    assign bus.write_flag    = w_flag;
    assign bus.write_value   = w_value;

    // Current flag view seen by E: the uncommitted W value overrides the register
    always_comb begin
        cur_vec = flags_q;
        pending = '0;
        for (int i = 0; i < NFLAGS; i++) begin
            if (w_valid && (w_flag == FW'(i))) begin
                cur_vec[i] = w_value;
            end
            pending[i] = (e_fwd && (e_flag == FW'(i))) || (w_valid && (w_flag == FW'(i)));
        end
    end

    // E-stage result evaluation
    always_comb begin
        e_result = 1'b0;
        case (e_op)
            OP_EQ:     e_result = (e_a == e_b);
            OP_NE:     e_result = (e_a != e_b);
            OP_UGE:    e_result = (e_a >= e_b);
            OP_UGT:    e_result = (e_a > e_b);
            OP_SGE:    e_result = ($signed(e_a) >= $signed(e_b));
            OP_SGT:    e_result = ($signed(e_a) > $signed(e_b));
            OP_SET:    e_result = 1'b1;
            OP_CLEAR:  e_result = 1'b0;
            OP_TOGGLE: e_result = !cur_vec[e_flag];
            OP_COPY:   e_result = cur_vec[e_src];
            default:   e_result = 1'b0;
        endcase
    end

    // Pipeline advance, commit and flush/reset handling
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid <= 1'b0;
            e_op    <= '0;
            e_flag  <= '0;
            e_src   <= '0;
            e_a     <= '0;
            e_b     <= '0;
            w_valid <= 1'b0;
            w_flag  <= '0;
            w_value <= 1'b0;
            flags_q <= '0;
        end else if (bus.flush) begin
            e_valid <= 1'b0;
            w_valid <= 1'b0;
        end else begin
            if (w_valid && bus.write_ready) begin
                flags_q[w_flag] <= w_value;
            end
            if (e_advance) begin
                w_valid <= e_fwd;
                if (e_fwd) begin
                    w_flag  <= e_flag;
                    w_value <= e_result;
                end
            end
            if (accept) begin
                e_valid <= 1'b1;
                e_op    <= bus.req_op;
                e_flag  <= bus.req_flag;
                e_src   <= bus.req_src_flag;
                e_a     <= bus.req_operand1;
                e_b     <= bus.req_operand2;
            end else if (e_advance) begin
                e_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: compare ops, bypass chain, backpressure, flush, reserved ops, reset.
module tb_flag_unit;
    logic clk;
    logic rst;
    int   checks;
    int   fails;

    flag_unit_if #(.XLEN(32), .NFLAGS(4)) bus ();

    flag_unit #(.XLEN(32), .NFLAGS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] op, input logic [1:0] f, input logic [1:0] s,
                             input logic [31:0] a, input logic [31:0] b);
        bus.req_valid    = 1'b1;
        bus.req_op       = op;
        bus.req_flag     = f;
        bus.req_src_flag = s;
        bus.req_operand1 = a;
        bus.req_operand2 = b;
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.flags !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b expected %b", bus.flags, 4'b0000); end
        checks++; if (bus.write_valid !== 1'b0) begin fails++; $display("FAIL reset_wvalid: got %b expected 0", bus.write_valid); end
        checks++; if (bus.flags_pending !== 4'b0000) begin fails++; $display("FAIL reset_pending: got %b expected 0000", bus.flags_pending); end
        checks++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_low: got %b expected 0", bus.req_ready); end
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_high: got %b expected 1", bus.req_ready); end
    endtask

    task automatic test_basic();
        bus.write_ready = 1'b1;
        drive_req(4'h0, 2'd2, 2'd0, 32'h1234, 32'h1234);
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL basic_ready: got %b expected 1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.flags_pending !== 4'b0100) begin fails++; $display("FAIL basic_pending_e: got %b expected 0100", bus.flags_pending); end
        checks++; if (bus.write_valid !== 1'b0) begin fails++; $display("FAIL basic_wvalid_n: got %b expected 0", bus.write_valid); end
        tick();
        checks++; if (bus.write_valid !== 1'b1) begin fails++; $display("FAIL basic_wvalid_n1: got %b expected 1", bus.write_valid); end
        checks++; if (bus.write_flag !== 2'd2) begin fails++; $display("FAIL basic_wflag: got %0d expected 2", bus.write_flag); end
        checks++; if (bus.write_value !== 1'b1) begin fails++; $display("FAIL basic_wvalue: got %b expected 1", bus.write_value); end
        checks++; if (bus.flags_pending !== 4'b0100) begin fails++; $display("FAIL basic_pending_w: got %b expected 0100", bus.flags_pending); end
        checks++; if (bus.flags !== 4'b0000) begin fails++; $display("FAIL basic_flags_n1: got %b expected 0000", bus.flags); end
        tick();
        checks++; if (bus.flags !== 4'b0100) begin fails++; $display("FAIL basic_flags_n2: got %b expected 0100", bus.flags); end
        checks++; if (bus.write_valid !== 1'b0) begin fails++; $display("FAIL basic_wvalid_n2: got %b expected 0", bus.write_valid); end
        checks++; if (bus.flags_pending !== 4'b0000) begin fails++; $display("FAIL basic_pending_n2: got %b expected 0000", bus.flags_pending); end
    endtask

    task automatic test_signed();
        apply_reset();
        bus.write_ready = 1'b1;
        drive_req(4'h3, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'h1);
        tick();
        drive_req(4'h5, 2'd1, 2'd0, 32'hFFFF_FFFF, 32'h1);
        tick();
        checks++; if ({bus.write_valid, bus.write_flag, bus.write_value} !== {1'b1, 2'd0, 1'b1}) begin fails++; $display("FAIL signed_ugt: got v%b f%0d d%b expected v1 f0 d1", bus.write_valid, bus.write_flag, bus.write_value); end
        drive_req(4'h4, 2'd3, 2'd0, 32'h5, 32'h5);
        tick();
        checks++; if ({bus.write_valid, bus.write_flag, bus.write_value} !== {1'b1, 2'd1, 1'b0}) begin fails++; $display("FAIL signed_sgt: got v%b f%0d d%b expected v1 f1 d0", bus.write_valid, bus.write_flag, bus.write_value); end
        checks++; if (bus.flags !== 4'b0001) begin fails++; $display("FAIL signed_flags_mid: got %b expected 0001", bus.flags); end
        bus.req_valid = 1'b0;
        tick();
        checks++; if ({bus.write_valid, bus.write_flag, bus.write_value} !== {1'b1, 2'd3, 1'b1}) begin fails++; $display("FAIL signed_sge: got v%b f%0d d%b expected v1 f3 d1", bus.write_valid, bus.write_flag, bus.write_value); end
        tick();
        checks++; if (bus.flags !== 4'b1001) begin fails++; $display("FAIL signed_flags_final: got %b expected 1001", bus.flags); end
        checks++; if (bus.write_valid !== 1'b0) begin fails++; $display("FAIL signed_wvalid_end: got %b expected 0", bus.write_valid); end
    endtask

    task automatic test_dependent();
        drive_req(4'h6, 2'd1, 2'd0, 32'h0, 32'h0);
        tick();
        drive_req(4'h8, 2'd1, 2'd0, 32'h0, 32'h0);
        tick();
        checks++; if ({bus.write_valid, bus.write_flag, bus.write_value} !== {1'b1, 2'd1, 1'b1}) begin fails++; $display("FAIL dep_set: got v%b f%0d d%b expected v1 f1 d1", bus.write_valid, bus.write_flag, bus.write_value); end
        drive_req(4'h9, 2'd0, 2'd1, 32'h0, 32'h0);
        tick();
        checks++; if ({bus.write_valid, bus.write_flag, bus.write_value} !== {1'b1, 2'd1, 1'b0}) begin fails++; $display("FAIL dep_toggle: got v%b f%0d d%b expected v1 f1 d0", bus.write_valid, bus.write_flag, bus.write_value); end
        checks++; if (bus.flags !== 4'b1011) begin fails++; $display("FAIL dep_flags_a: got %b expected 1011", bus.flags); end
        bus.req_valid = 1'b0;
        tick();
        checks++; if ({bus.write_valid, bus.write_flag, bus.write_value} !== {1'b1, 2'd0, 1'b0}) begin fails++; $display("FAIL dep_copy: got v%b f%0d d%b expected v1 f0 d0", bus.write_valid, bus.write_flag, bus.write_value); end
        checks++; if (bus.flags !== 4'b1001) begin fails++; $display("FAIL dep_flags_b: got %b expected 1001", bus.flags); end
        tick();
        checks++; if (bus.flags !== 4'b1000) begin fails++; $display("FAIL dep_flags_final: got %b expected 1000", bus.flags); end
        checks++; if (bus.write_valid !== 1'b0) begin fails++; $display("FAIL dep_wvalid_end: got %b expected 0", bus.write_valid); end
    endtask

    task automatic test_backpressure();
        bus.write_ready = 1'b0;
        drive_req(4'h6, 2'd0, 2'd0, 32'h0, 32'h0);
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_c0: got %b expected 1", bus.req_ready); end
        tick();
        drive_req(4'h7, 2'd3, 2'd0, 32'h0, 32'h0);
        tick();
        checks++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_c2: got %b expected 0", bus.req_ready); end
        checks++; if ({bus.write_valid, bus.write_flag, bus.write_value} !== {1'b1, 2'd0, 1'b1}) begin fails++; $display("FAIL bp_w_hold_a: got v%b f%0d d%b expected v1 f0 d1", bus.write_valid, bus.write_flag, bus.write_value); end
        drive_req(4'h8, 2'd2, 2'd0, 32'h0, 32'h0);
        tick();
        checks++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_c3: got %b expected 0", bus.req_ready); end
        checks++; if (bus.flags !== 4'b1000) begin fails++; $display("FAIL bp_flags_hold_a: got %b expected 1000", bus.flags); end
        checks++; if (bus.flags_pending !== 4'b1001) begin fails++; $display("FAIL bp_pending: got %b expected 1001", bus.flags_pending); end
        tick();
        checks++; if (bus.flags !== 4'b1000) begin fails++; $display("FAIL bp_flags_hold_b: got %b expected 1000", bus.flags); end
        checks++; if ({bus.write_valid, bus.write_flag, bus.write_value} !== {1'b1, 2'd0, 1'b1}) begin fails++; $display("FAIL bp_w_hold_b: got v%b f%0d d%b expected v1 f0 d1", bus.write_valid, bus.write_flag, bus.write_value); end
        bus.write_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_release: got %b expected 1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.flags !== 4'b1001) begin fails++; $display("FAIL bp_commit1: got %b expected 1001", bus.flags); end
        checks++; if ({bus.write_valid, bus.write_flag, bus.write_value} !== {1'b1, 2'd3, 1'b0}) begin fails++; $display("FAIL bp_w2: got v%b f%0d d%b expected v1 f3 d0", bus.write_valid, bus.write_flag, bus.write_value); end
        tick();
        checks++; if (bus.flags !== 4'b0001) begin fails++; $display("FAIL bp_commit2: got %b expected 0001", bus.flags); end
        checks++; if ({bus.write_valid, bus.write_flag, bus.write_value} !== {1'b1, 2'd2, 1'b1}) begin fails++; $display("FAIL bp_w3: got v%b f%0d d%b expected v1 f2 d1", bus.write_valid, bus.write_flag, bus.write_value); end
        tick();
        checks++; if (bus.flags !== 4'b0101) begin fails++; $display("FAIL bp_commit3: got %b expected 0101", bus.flags); end
        checks++; if (bus.write_valid !== 1'b0) begin fails++; $display("FAIL bp_no_dup: got %b expected 0", bus.write_valid); end
    endtask

    task automatic test_flush();
        apply_reset();
        bus.write_ready = 1'b1;
        drive_req(4'h6, 2'd1, 2'd0, 32'h0, 32'h0);
        tick();
        drive_req(4'h6, 2'd3, 2'd0, 32'h0, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        checks++; if (bus.flags !== 4'b1010) begin fails++; $display("FAIL flush_setup: got %b expected 1010", bus.flags); end
        drive_req(4'h6, 2'd0, 2'd0, 32'h0, 32'h0);
        tick();
        drive_req(4'h6, 2'd2, 2'd0, 32'h0, 32'h0);
        tick();
        bus.flush = 1'b1;
        drive_req(4'h7, 2'd3, 2'd0, 32'h0, 32'h0);
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b expected 0", bus.req_ready); end
        checks++; if (bus.flags_pending !== 4'b0101) begin fails++; $display("FAIL flush_pre_pending: got %b expected 0101", bus.flags_pending); end
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        checks++; if (bus.write_valid !== 1'b0) begin fails++; $display("FAIL flush_wvalid: got %b expected 0", bus.write_valid); end
        checks++; if (bus.flags_pending !== 4'b0000) begin fails++; $display("FAIL flush_pending: got %b expected 0000", bus.flags_pending); end
        checks++; if (bus.flags !== 4'b1010) begin fails++; $display("FAIL flush_no_commit: got %b expected 1010", bus.flags); end
        tick();
        tick();
        checks++; if (bus.flags !== 4'b1010) begin fails++; $display("FAIL flush_no_late_commit: got %b expected 1010", bus.flags); end
        checks++; if (bus.write_valid !== 1'b0) begin fails++; $display("FAIL flush_not_accepted: got %b expected 0", bus.write_valid); end
    endtask

    task automatic test_reserved_reset();
        drive_req(4'hC, 2'd1, 2'd0, 32'h0, 32'h0);
        tick();
        checks++; if (bus.flags_pending !== 4'b0000) begin fails++; $display("FAIL rsv_pending: got %b expected 0000", bus.flags_pending); end
        drive_req(4'h6, 2'd0, 2'd0, 32'h0, 32'h0);
        tick();
        checks++; if (bus.write_valid !== 1'b0) begin fails++; $display("FAIL rsv_no_commit: got %b expected 0", bus.write_valid); end
        checks++; if (bus.flags_pending !== 4'b0001) begin fails++; $display("FAIL rsv_next_pending: got %b expected 0001", bus.flags_pending); end
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready_low: got %b expected 0", bus.req_ready); end
        tick();
        checks++; if (bus.flags !== 4'b0000) begin fails++; $display("FAIL rst_flags: got %b expected 0000", bus.flags); end
        checks++; if (bus.write_valid !== 1'b0) begin fails++; $display("FAIL rst_wvalid: got %b expected 0", bus.write_valid); end
        checks++; if (bus.flags_pending !== 4'b0000) begin fails++; $display("FAIL rst_pending: got %b expected 0000", bus.flags_pending); end
        checks++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready_hold: got %b expected 0", bus.req_ready); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_return: got %b expected 1", bus.req_ready); end
        checks++; if (bus.flags !== 4'b0000) begin fails++; $display("FAIL rst_flags_after: got %b expected 0000", bus.flags); end
    endtask

    // Scenario sequence
    initial begin
        checks           = 0;
        fails            = 0;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_op       = 4'h0;
        bus.req_flag     = 2'd0;
        bus.req_src_flag = 2'd0;
        bus.req_operand1 = 32'h0;
        bus.req_operand2 = 32'h0;
        bus.flush        = 1'b0;
        bus.write_ready  = 1'b1;
        test_reset();
        test_basic();
        test_signed();
        test_dependent();
        test_backpressure();
        test_flush();
        test_reserved_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
